// File: rtl/mmu.sv
// rtl/mmu.sv - virtual-to-physical translation, byte strobes and read alignment between CPU and RAM
//
// Purpose:
//   Translates 16-bit CPU virtual addresses through a 16-entry page table
//   {W, V, frame}. Generates byte-lane strobes and duplicated write data for
//   RAM. Aligns and optionally sign-extends the read data that RAM returns one
//   cycle later. Page table, index, map enable and fault status are reached
//   over three IO ports starting at IO_BASE.
//
// Configuration macro:
//   MMU_PROTECT_EN - when defined, W bits are stored and writes to W=0 pages
//                    fault. When undefined, every page is writable.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cpu_*               CPU access: address, byte/word, write, data, sign-extend
//   o_cpu_read_data       aligned read data (RAM data delayed by one cycle)
//   i_io_write/addr/wdata IO port write strobe, port number and data
//   o_io_rdata            status word on IO_BASE+2, otherwise 0
//   o_ram_*               physical word address, write enable, byte strobes, data
//   i_ram_rdata           RAM read data, one cycle after the address
//   o_fault               sticky fault flag
module mmu #(
   parameter int         FRAME_W = 8,
   parameter logic [7:0] IO_BASE = 8'h10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [15:0]        i_cpu_addr,
   input  logic               i_cpu_byte_enable,
   input  logic               i_cpu_write_enable,
   input  logic [15:0]        i_cpu_write_data,
   input  logic               i_cpu_sign_extend,
   output logic [15:0]        o_cpu_read_data,
   input  logic               i_io_write,
   input  logic [7:0]         i_io_addr,
   input  logic [15:0]        i_io_wdata,
   output logic [15:0]        o_io_rdata,
   output logic [10+FRAME_W:0] o_ram_addr,
   output logic               o_ram_we,
   output logic [1:0]         o_ram_be,
   output logic [15:0]        o_ram_wdata,
   input  logic [15:0]        i_ram_rdata,
   output logic               o_fault
);

   localparam int         PA_W    = 12 + FRAME_W;
   localparam logic [7:0] IO_IDX  = IO_BASE;
   localparam logic [7:0] IO_TBL  = IO_BASE + 8'd1;
   localparam logic [7:0] IO_STAT = IO_BASE + 8'd2;

   logic [FRAME_W-1:0] r_frame [16];
   logic [15:0]        r_valid;
   logic [3:0]         r_index;
   logic               r_map_en;
   logic               r_fault;
   logic [15:0]        r_fault_vaddr;

   // Read-return state captured in the access cycle, used when RAM data arrives.
   logic               r_lane;
   logic               r_byte;
   logic               r_sext;
   logic               r_rfault;

   logic [3:0]         w_page;
   logic               w_writable;
   logic               w_fault;
   logic [PA_W-1:0]    w_paddr;
   logic [7:0]         w_byte_sel;
   logic               w_io_idx;
   logic               w_io_tbl;
   logic               w_io_stat;
   logic               w_unused;

   assign w_page    = i_cpu_addr[15:12];
   assign w_io_idx  = i_io_write && (i_io_addr == IO_IDX);
   assign w_io_tbl  = i_io_write && (i_io_addr == IO_TBL);
   assign w_io_stat = i_io_write && (i_io_addr == IO_STAT);

`ifdef MMU_PROTECT_EN
   logic [15:0] r_writable;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_writable <= '0;
      end else if (w_io_tbl) begin
         r_writable[r_index] <= i_io_wdata[15];
      end
   end

   assign w_writable = r_writable[w_page];
`else
   assign w_writable = 1'b1;
`endif

   assign w_fault = r_map_en && (!r_valid[w_page] || (i_cpu_write_enable && !w_writable));
   assign w_paddr = r_map_en ? {r_frame[w_page], i_cpu_addr[11:0]} : PA_W'(i_cpu_addr);

   assign o_ram_addr  = w_paddr[PA_W-1:1];
   assign o_ram_we    = i_cpu_write_enable && !w_fault && !i_rst;
   assign o_ram_be    = !i_cpu_byte_enable ? 2'b11 : (i_cpu_addr[0] ? 2'b10 : 2'b01);
   assign o_ram_wdata = i_cpu_byte_enable ? {2{i_cpu_write_data[7:0]}} : i_cpu_write_data;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) begin
            r_frame[i] <= '0;
         end
         r_valid  <= '0;
         r_index  <= '0;
         r_map_en <= 1'b0;
      end else begin
         if (w_io_idx) begin
            r_index <= i_io_wdata[3:0];
         end
         if (w_io_tbl) begin
            r_frame[r_index] <= i_io_wdata[FRAME_W-1:0];
            r_valid[r_index] <= i_io_wdata[14];
         end
         if (w_io_stat) begin
            r_map_en <= i_io_wdata[0];
         end
      end
   end

   // Clear is written first so that a fault in the same cycle wins.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fault       <= 1'b0;
         r_fault_vaddr <= '0;
      end else begin
         if (w_io_stat && i_io_wdata[1]) begin
            r_fault <= 1'b0;
         end
         if (w_fault) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
               r_fault_vaddr <= i_cpu_addr;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lane   <= 1'b0;
         r_byte   <= 1'b0;
         r_sext   <= 1'b0;
         r_rfault <= 1'b0;
      end else begin
         r_lane   <= i_cpu_addr[0];
         r_byte   <= i_cpu_byte_enable;
         r_sext   <= i_cpu_sign_extend;
         r_rfault <= w_fault && !i_cpu_write_enable;
      end
   end

   assign w_byte_sel = r_lane ? i_ram_rdata[15:8] : i_ram_rdata[7:0];

   always_comb begin
      o_cpu_read_data = i_ram_rdata;
      if (r_rfault) begin
         o_cpu_read_data = 16'h0000;
      end else if (r_byte) begin
         o_cpu_read_data = {{8{r_sext && w_byte_sel[7]}}, w_byte_sel};
      end
   end

   assign o_io_rdata = (i_io_addr == IO_STAT) ?
                       {r_fault_vaddr[15:3], 1'b0, r_fault, r_map_en} : 16'h0000;
   assign o_fault    = r_fault;

   // Bits that the port map deliberately leaves unread.
   assign w_unused = ^{i_io_wdata, r_fault_vaddr[2:0], w_paddr[0]};

endmodule

// File: tb/tb_mmu.sv
// tb/tb_mmu.sv - directed bench for mmu with a page-table/memory reference model
module tb_mmu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic        cpu_be = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_wd = '0;
   logic        cpu_sext = 1'b0;
   logic [15:0] cpu_rd;
   logic        io_write = 1'b0;
   logic [7:0]  io_addr = '0;
   logic [15:0] io_wdata = '0;
   logic [15:0] io_rdata;
   logic [18:0] ram_addr;
   logic        ram_we;
   logic [1:0]  ram_be;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata = '0;
   logic        fault;

   always #5 clk = ~clk;

   mmu #(.FRAME_W(8), .IO_BASE(8'h10)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_cpu_addr(cpu_addr),
      .i_cpu_byte_enable(cpu_be),
      .i_cpu_write_enable(cpu_we),
      .i_cpu_write_data(cpu_wd),
      .i_cpu_sign_extend(cpu_sext),
      .o_cpu_read_data(cpu_rd),
      .i_io_write(io_write),
      .i_io_addr(io_addr),
      .i_io_wdata(io_wdata),
      .o_io_rdata(io_rdata),
      .o_ram_addr(ram_addr),
      .o_ram_we(ram_we),
      .o_ram_be(ram_be),
      .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata),
      .o_fault(fault)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: page table, map enable, sticky fault.
   logic        m_map = 1'b0;
   logic        m_fault = 1'b0;
   logic [15:0] m_vaddr = '0;
   logic [3:0]  m_idx = '0;
   logic        m_v [16];
   logic        m_w [16];
   logic [7:0]  m_frame [16];

   // Physical RAM driven by the DUT's RAM port.
   logic [15:0] mem [0:524287];
   logic [15:0] exp_rd = '0;
   logic        exp_chk = 1'b0;

   function automatic logic m_fault_now();
      logic wr_ok;
`ifdef MMU_PROTECT_EN
      wr_ok = m_w[cpu_addr[15:12]];
`else
      wr_ok = 1'b1;
`endif
      return m_map && (!m_v[cpu_addr[15:12]] || (cpu_we && !wr_ok));
   endfunction

   function automatic logic [19:0] m_paddr();
      if (m_map) return {m_frame[cpu_addr[15:12]], cpu_addr[11:0]};
      return {4'h0, cpu_addr};
   endfunction

   function automatic logic [18:0] m_waddr();
      logic [19:0] p;
      p = m_paddr();
      return p[19:1];
   endfunction

   function automatic logic [15:0] m_read_value(input logic [15:0] w, input logic in_rst);
      logic [15:0] b;
      if (in_rst || !cpu_be) return w;
      b = cpu_addr[0] ? (w >> 8) : (w & 16'h00FF);
      if (cpu_sext && b >= 16'd128) return b + 16'hFF00;
      return b;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_map   <= 1'b0;
         m_fault <= 1'b0;
         m_vaddr <= '0;
         m_idx   <= '0;
         for (int i = 0; i < 16; i++) begin
            m_v[i]     <= 1'b0;
            m_w[i]     <= 1'b0;
            m_frame[i] <= '0;
         end
      end else begin
         if (io_write && io_addr == 8'h10) m_idx <= io_wdata[3:0];
         if (io_write && io_addr == 8'h11) begin
            m_w[m_idx]     <= io_wdata[15];
            m_v[m_idx]     <= io_wdata[14];
            m_frame[m_idx] <= io_wdata[7:0];
         end
         if (io_write && io_addr == 8'h12) begin
            m_map <= io_wdata[0];
            if (io_wdata[1]) m_fault <= 1'b0;
         end
         if (m_fault_now()) begin
            m_fault <= 1'b1;
            if (!m_fault) m_vaddr <= cpu_addr;
         end
      end
   end

   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      exp_chk   <= rst || !cpu_we;
      exp_rd    <= (!rst && m_fault_now()) ? 16'h0000 : m_read_value(mem[m_waddr()], rst);
      if (ram_we) begin
         if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
         if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ram_addr", {13'h0, ram_addr}, {12'h0, m_paddr()} >> 1);
         check("ram_we", {31'h0, ram_we}, {31'h0, cpu_we && !m_fault_now() && !rst});
         check("ram_be", {30'h0, ram_be}, !cpu_be ? 32'd3 : (cpu_addr[0] ? 32'd2 : 32'd1));
         check("ram_wdata", {16'h0, ram_wdata}, cpu_be ? {16'h0, cpu_wd[7:0], cpu_wd[7:0]} : {16'h0, cpu_wd});
         check("fault", {31'h0, fault}, {31'h0, m_fault});
         check("io_rdata", {16'h0, io_rdata},
               io_addr == 8'h12 ? {16'h0, m_vaddr[15:3], 1'b0, m_fault, m_map} : 32'h0);
         if (rst) check("read_in_reset", {16'h0, cpu_rd}, {16'h0, ram_rdata});
         else if (exp_chk) check("cpu_read_data", {16'h0, cpu_rd}, {16'h0, exp_rd});
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic io_wr(input logic [7:0] a, input logic [15:0] d);
      io_write = 1'b1;
      io_addr  = a;
      io_wdata = d;
      next();
      io_write = 1'b0;
   endtask

   initial begin
      next();
      chk_en = 1'b1;
      next();
      rst = 1'b0;
      io_addr = 8'h12;
      @(negedge clk);
      check("reset_fault", {31'h0, fault}, 32'h0);
      check("reset_status", {16'h0, io_rdata}, 32'h0);

      cpu_addr = 16'h0124; cpu_we = 1'b1; cpu_be = 1'b0; cpu_wd = 16'hBEEF;
      @(negedge clk);
      check("lit_word_addr", {13'h0, ram_addr}, 32'h92);
      check("lit_word_be", {30'h0, ram_be}, 32'h3);
      check("lit_word_we", {31'h0, ram_we}, 32'h1);
      next();
      cpu_we = 1'b0;
      next();
      cpu_we = 1'b1; cpu_wd = 16'h80AA;
      @(negedge clk);
      check("lit_readback", {16'h0, cpu_rd}, 32'hBEEF);
      next();
      cpu_we = 1'b0; cpu_be = 1'b1; cpu_addr = 16'h0125; cpu_sext = 1'b1;
      next();
      cpu_sext = 1'b0;
      @(negedge clk);
      check("lit_byte_sext", {16'h0, cpu_rd}, 32'hFF80);
      next();
      cpu_be = 1'b0; cpu_addr = 16'h3000;
      @(negedge clk);
      check("lit_byte_zext", {16'h0, cpu_rd}, 32'h0080);
      next();

      io_wr(8'h10, 16'h0003);
      io_wr(8'h11, 16'hC05A);
      io_wr(8'h12, 16'h0001);
      cpu_addr = 16'h3ABC; cpu_be = 1'b1; cpu_we = 1'b1; cpu_wd = 16'h0011;
      @(negedge clk);
      check("lit_map_addr", {13'h0, ram_addr}, 32'h2D55E);
      check("lit_map_be", {30'h0, ram_be}, 32'h1);
      check("lit_map_wdata", {16'h0, ram_wdata}, 32'h1111);
      check("lit_map_we", {31'h0, ram_we}, 32'h1);
      next();

      cpu_be = 1'b0; cpu_addr = 16'h7123; cpu_wd = 16'h5555; io_addr = 8'h12;
      @(negedge clk);
      check("lit_fault_we", {31'h0, ram_we}, 32'h0);
      next();
      cpu_we = 1'b0; cpu_addr = 16'h3000;
      @(negedge clk);
      check("lit_fault_set", {31'h0, fault}, 32'h1);
      check("lit_fault_vaddr", {16'h0, io_rdata}, 32'h7123);
      next();
      cpu_addr = 16'h8456;
      next();
      cpu_addr = 16'h3000;
      @(negedge clk);
      check("lit_fault_read_zero", {16'h0, cpu_rd}, 32'h0);
      check("lit_fault_vaddr_kept", {16'h0, io_rdata}, 32'h7123);
      next();
      io_wr(8'h12, 16'h0003);
      @(negedge clk);
      check("lit_fault_clear", {16'h0, io_rdata}, 32'h7121);

      io_wr(8'h10, 16'h0004);
      io_wr(8'h11, 16'h4022);
      cpu_addr = 16'h4010; cpu_we = 1'b1; cpu_wd = 16'h1234;
      @(negedge clk);
`ifdef MMU_PROTECT_EN
      check("lit_protect_we", {31'h0, ram_we}, 32'h0);
`else
      check("lit_protect_we", {31'h0, ram_we}, 32'h1);
`endif
      next();
      cpu_we = 1'b0; cpu_addr = 16'h3000;
      @(negedge clk);
`ifdef MMU_PROTECT_EN
      check("lit_protect_fault", {31'h0, fault}, 32'h1);
`else
      check("lit_protect_fault", {31'h0, fault}, 32'h0);
`endif
      io_wr(8'h12, 16'h0003);

      cpu_addr = 16'h9000;
      io_wr(8'h12, 16'h0003);
      cpu_addr = 16'h3000;
      @(negedge clk);
      check("lit_set_wins", {31'h0, fault}, 32'h1);
      io_wr(8'h12, 16'h0003);
      @(negedge clk);
      check("lit_cleared", {31'h0, fault}, 32'h0);

      cpu_addr = 16'h3002; cpu_we = 1'b1; cpu_wd = 16'hAAAA;
      #2;
      check("lit_pre_reset_we", {31'h0, ram_we}, 32'h1);
      rst = 1'b1;
      #1;
      check("lit_reset_we", {31'h0, ram_we}, 32'h0);
      next();
      rst = 1'b0; cpu_we = 1'b0; io_addr = 8'h12;
      @(negedge clk);
      check("lit_post_reset_status", {16'h0, io_rdata}, 32'h0);
      check("lit_no_write", {31'h0, mem[19'h2D001] == 16'hAAAA}, 32'h0);
      io_wr(8'h12, 16'h0001);
      next();
      @(negedge clk);
      check("lit_table_invalid", {31'h0, fault}, 32'h1);
      next();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
